// File: rtl/video_timing.sv
// Raster timing generator: registered h/v counters with sync/enable decode, plus
// a shift-register copy of sync/de delayed by the downstream scene latency.
module video_timing #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int HSYNC_POL  = 1,
  parameter int VSYNC_POL  = 1,
  parameter int PIPE_DELAY = 4
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        de,
  output logic        frame_start,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de
);

  // state    | meaning
  // ST_RESET | just out of reset; next edge presents position (0,0)
  // ST_RUN   | free-running, each edge advances one position

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_check
      $error("video_timing: H_TOTAL and V_TOTAL must not exceed 2048");
    end
    if (PIPE_DELAY < 0) begin : g_delay_check
      $error("video_timing: PIPE_DELAY must be non-negative");
    end
  endgenerate

  // 12-bit compares so a 2048-wide boundary does not alias to zero
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] H_HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON      = (HSYNC_POL != 0);
  localparam logic        VS_ON      = (VSYNC_POL != 0);

  typedef enum logic {ST_RESET, ST_RUN} state_t;

  state_t      state, state_next;
  logic [10:0] h_next, v_next;
  logic [11:0] h_ext, v_ext;
  logic        hs_next, vs_next, de_next, fs_next;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    h_next     = hcount;
    v_next     = vcount;
    case (state)
      ST_RESET: begin
        state_next = ST_RUN;
        h_next     = 11'd0;
        v_next     = 11'd0;
      end
      ST_RUN: begin
        if ({1'b0, hcount} == H_LAST) begin
          h_next = 11'd0;
          if ({1'b0, vcount} == V_LAST) v_next = 11'd0;
          else                          v_next = vcount + 11'd1;
        end else begin
          h_next = hcount + 11'd1;
        end
      end
      default: state_next = ST_RESET;
    endcase

    // Decode from the position about to be registered so all outputs agree
    h_ext   = {1'b0, h_next};
    v_ext   = {1'b0, v_next};
    hs_next = (h_ext >= H_HS_START && h_ext < H_HS_END) ? HS_ON : ~HS_ON;
    vs_next = (v_ext >= V_VS_START && v_ext < V_VS_END) ? VS_ON : ~VS_ON;
    de_next = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    fs_next = (h_next == 11'd0) && (v_next == 11'd0);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      de          <= de_next;
      frame_start <= fs_next;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign vid_hsync = hsync;
      assign vid_vsync = vsync;
      assign vid_de    = de;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe, vs_pipe, de_pipe;

      always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
          hs_pipe <= {PIPE_DELAY{~HS_ON}};
          vs_pipe <= {PIPE_DELAY{~VS_ON}};
          de_pipe <= '0;
        end else begin
          hs_pipe[0] <= hsync;
          vs_pipe[0] <= vsync;
          de_pipe[0] <= de;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            de_pipe[i] <= de_pipe[i-1];
          end
        end
      end

      assign vid_hsync = hs_pipe[PIPE_DELAY-1];
      assign vid_vsync = vs_pipe[PIPE_DELAY-1];
      assign vid_de    = de_pipe[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing generator directly upstream of the scene/camera ray stage.
- Produces the pixel-clock-domain hsync, vsync and hcount/vcount that drive camera and scene.
- Also produces a copy of sync and data-enable delayed by the scene pipeline latency, so the display sees sync aligned with pixel_data.
- Single clock domain (pixel_clk); no handshakes; free-running once out of reset.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 110, horizontal front porch (cycles)
H_SYNC, 40, horizontal sync width (cycles)
H_BP, 220, horizontal back porch (cycles)
V_ACTIVE, 720, visible lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 20, vertical back porch (lines)
HSYNC_POL, 1, 1 = hsync active-high, 0 = active-low
VSYNC_POL, 1, 1 = vsync active-high, 0 = active-low
PIPE_DELAY, 4, scene latency in cycles applied to vid_* outputs (0 allowed)

Ports:
pixel_clk  input  1  pixel clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
hsync  output  1  horizontal sync, undelayed (to camera/scene)
vsync  output  1  vertical sync, undelayed (to camera/scene)
hcount  output  11  current horizontal position, 0..H_TOTAL-1
vcount  output  11  current line, 0..V_TOTAL-1
de  output  1  undelayed data enable: high when hcount<H_ACTIVE and vcount<V_ACTIVE
frame_start  output  1  one-cycle pulse when hcount==0 and vcount==0
vid_hsync  output  1  hsync delayed PIPE_DELAY cycles
vid_vsync  output  1  vsync delayed PIPE_DELAY cycles
vid_de  output  1  de delayed PIPE_DELAY cycles

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 2048; elaboration error otherwise.
- Line order: active, front porch, sync, back porch. Frame order is the same, counted in lines.
- Reset (rst_n low, asynchronous): hcount=0, vcount=0, de=0, frame_start=0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - All delay-line stages and vid_* outputs take the same inactive values (vid_de=0).
- First rising edge after rst_n deasserts: outputs present position (0,0) with de=1 and frame_start=1. Each later edge advances by one position.
- Counters:
  - hcount wraps H_TOTAL-1 -> 0.
  - vcount increments only on the edge where hcount wraps; vcount wraps V_TOTAL-1 -> 0 on the same edge that hcount wraps.
- All undelayed outputs are registered and mutually consistent: in any cycle, hsync/vsync/de/frame_start are decoded from the hcount/vcount shown in that cycle.
- Sync decode:
  - hsync active iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC, for the whole line, independent of hcount.
- Delay line:
  - vid_X(cycle n) = X(cycle n-PIPE_DELAY), implemented as a PIPE_DELAY-stage shift register.
  - PIPE_DELAY=0: vid_X is a wire copy of X.
  - During the first PIPE_DELAY cycles after reset, vid_* show the reset (inactive) values.
- Reset asserted mid-frame: all outputs return immediately (asynchronously) to reset values. Restart is always at (0,0); there is no resume.
- No other inputs. Timing is fixed by parameters.

Test Plan:
All tests use H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), PIPE_DELAY=3, both polarities 1, unless noted.

1. Reset release -> first cycle hcount=0, vcount=0, de=1, frame_start=1. hcount reaches 15 on the 16th cycle, then 0 with vcount=1.
2. Sync and enable windows:
   - hsync high exactly for hcount 10..12 on every line.
   - vsync high for all 32 cycles of lines 5..6.
   - de high only for hcount 0..7 on lines 0..3: 32 cycles per 128-cycle frame.
3. Frame wrap -> after (15,7) comes (0,0) with frame_start=1. frame_start pulses exactly once every 128 cycles and is 1 cycle wide.
4. Delay alignment:
   - vid_hsync/vid_vsync/vid_de equal hsync/vsync/de from 3 cycles earlier, over 2 full frames.
   - vid_* are 0 for the first 3 cycles after reset.
   - With PIPE_DELAY=0, vid_* equal the undelayed outputs in the same cycle.
5. Polarity: HSYNC_POL=0, VSYNC_POL=0 -> hsync=1 during reset, 0 only at hcount 10..12; vsync low only on lines 5..6.
6. Mid-frame reset: assert rst_n=0 at (6,2) asynchronously between edges -> outputs go immediately to reset values (including vid_*). After release, restart at (0,0) with frame_start=1.
